date_to_day_encoder: RTL and testbench
======================================

Name: date_to_day_encoder

Overview:
- Sequential inverse of the day-count-to-month/day path. Takes a calendar date entered as BCD month and BCD day (from switches/keys).
- Computes the ordinal day-of-year and returns it as three BCD digits, ready for the seven-segment decoders.
- Sits between the user-input front end and the HEX display path. Runs on the board's 10 MHz clock.

Parameters:
- LEAP_YEAR, 0, 1 = February has 29 days (year length 366); 0 = 28 days (year length 365).

Ports:
- ADC_CLK_10  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled each rising edge, acted on only in IDLE.
- month_msb  input  4  BCD tens digit of month.
- month_lsb  input  4  BCD units digit of month.
- day_msb  input  4  BCD tens digit of day.
- day_lsb  input  4  BCD units digit of day.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when a valid result is written.
- error  output  1  one-cycle pulse when the latched date is invalid.
- doy_hundreds  output  4  BCD hundreds digit of day-of-year.
- doy_tens  output  4  BCD tens digit.
- doy_ones  output  4  BCD units digit.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - busy, done, error, and all doy digits go to 0.
  - Internal accumulator and month index are cleared.
- FSM states: IDLE, CHECK, ACCUM, CONVERT.
- IDLE:
  - When start=1 at edge E0, latch all four input digits, set busy=1, go to CHECK.
  - Input changes after E0 are ignored until the next IDLE.
- CHECK (edge E1):
  - Date is valid iff all four digits ≤ 9, month = 10*msb+lsb in 1..12, and day = 10*msb+lsb in 1..dim(month).
  - dim table: 31,28(+LEAP_YEAR),31,30,31,30,31,31,30,31,30,31.
  - Valid: acc = 0, month index m = 1, go to ACCUM.
  - Invalid: pulse error for one cycle, busy=0, return to IDLE. doy digits keep their previous values.
- ACCUM: one month per edge.
  - While m < month: acc += dim(m), m += 1.
  - When m == month: acc += day, load a 9-bit shift count, go to CONVERT.
  - acc is 9-bit binary; maximum value 366, no overflow.
- CONVERT:
  - Binary-to-BCD double-dabble, one bit per edge, exactly 9 edges.
  - Add-3 applies to any BCD nibble ≥ 5 before each shift.
  - On the 9th edge: write doy_hundreds/tens/ones, pulse done for one cycle, busy=0, return to IDLE.
- Latency, counted in rising edges after E0:
  - done asserts after edge month+10, i.e. 11 for January through 22 for December.
  - error asserts after edge 1.
- busy is high from after E0 through the edge that asserts done or error, inclusive.
- done and error are never high together.
- start while busy is ignored (not queued).
- A start held high in IDLE after completion begins a new conversion on the next edge.
- doy digits change only on the done edge. They hold their value between conversions and across error.
- Reset mid-operation aborts immediately: no done or error pulse, outputs zeroed.

Test Plan:
- Reset, then start with 0,1 / 0,1 (01/01) -> done after exactly 11 clocks; doy = 0,0,1; busy high for 11 clocks.
- Start with 1,2 / 3,1 (12/31), LEAP_YEAR=0 -> done after 22 clocks; doy = 3,6,5. With LEAP_YEAR=1 -> doy = 3,6,6.
- After 12/31 completes, start with 0,2 / 2,9 (02/29), LEAP_YEAR=0 -> error pulse 1 clock after start; no done; doy remains 3,6,5. With LEAP_YEAR=1 -> done after 12 clocks; doy = 0,6,0.
- Invalid inputs, each -> error only, outputs unchanged:
  - Non-BCD month_lsb=0xA.
  - Month 13.
  - Day 00.
  - Day 0,4 / 3,1 (April 31).
- Start 0,7 / 0,4 (07/04 -> 185), then pulse start with 0,1 / 0,1 and change the inputs mid-conversion -> second start ignored; done once; doy = 1,8,5.
- Assert reset_n low during CONVERT of 09/15 -> outputs 0 immediately, no done pulse. After release, a new start of 09/15 -> doy = 2,5,8.

Source files
------------

// File: rtl/date_to_day_encoder.sv
// Converts a BCD calendar date (month/day) into a three-digit BCD day-of-year.
// Multi-cycle: validate, accumulate month lengths one per clock, then double-dabble.
module date_to_day_encoder #(
  parameter int LEAP_YEAR = 0
) (
  input  logic       ADC_CLK_10,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] month_msb,
  input  logic [3:0] month_lsb,
  input  logic [3:0] day_msb,
  input  logic [3:0] day_lsb,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] doy_hundreds,
  output logic [3:0] doy_tens,
  output logic [3:0] doy_ones
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    ACCUM   = 2'd2,
    CONVERT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  mon_msb_q, mon_msb_d;
  logic [3:0]  mon_lsb_q, mon_lsb_d;
  logic [3:0]  day_msb_q, day_msb_d;
  logic [3:0]  day_lsb_q, day_lsb_d;
  logic [8:0]  acc_q, acc_d;
  logic [3:0]  m_idx_q, m_idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [20:0] dd_q, dd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;

  // Days in month for a binary month index 1..12; anything else yields 0.
  function automatic logic [4:0] dim(input logic [3:0] m);
    logic [4:0] r;
    case (m)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: r = 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                    r = 5'd30;
      4'd2:    r = (LEAP_YEAR != 0) ? 5'd29 : 5'd28;
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  logic [7:0] month_bin;
  logic [7:0] day_bin;
  logic       digits_ok;
  logic       month_ok;
  logic       day_ok;
  logic       date_ok;
  logic [4:0] month_len;

  always_comb begin
    month_bin = ({4'd0, mon_msb_q} * 8'd10) + {4'd0, mon_lsb_q};
    day_bin   = ({4'd0, day_msb_q} * 8'd10) + {4'd0, day_lsb_q};
    digits_ok = (mon_msb_q <= 4'd9) && (mon_lsb_q <= 4'd9) &&
                (day_msb_q <= 4'd9) && (day_lsb_q <= 4'd9);
    month_ok  = (month_bin >= 8'd1) && (month_bin <= 8'd12);
    month_len = dim(month_bin[3:0]);
    day_ok    = (day_bin >= 8'd1) && (day_bin <= {3'd0, month_len});
    date_ok   = digits_ok && month_ok && day_ok;
  end

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  logic [11:0] bcd_adj;
  logic [20:0] dd_shift;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dabble
      logic [3:0] nib;
      assign nib = dd_q[9 + gi*4 +: 4];
      assign bcd_adj[gi*4 +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
  endgenerate

  assign dd_shift = {bcd_adj[10:0], dd_q[8:0], 1'b0};

  always_comb begin
    state_d   = state_q;
    mon_msb_d = mon_msb_q;
    mon_lsb_d = mon_lsb_q;
    day_msb_d = day_msb_q;
    day_lsb_d = day_lsb_q;
    acc_d     = acc_q;
    m_idx_d   = m_idx_q;
    cnt_d     = cnt_q;
    dd_d      = dd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    hund_d    = hund_q;
    tens_d    = tens_q;
    ones_d    = ones_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mon_msb_d = month_msb;
          mon_lsb_d = month_lsb;
          day_msb_d = day_msb;
          day_lsb_d = day_lsb;
          busy_d    = 1'b1;
          state_d   = CHECK;
        end
      end

      CHECK: begin
        if (date_ok) begin
          acc_d   = 9'd0;
          m_idx_d = 4'd1;
          state_d = ACCUM;
        end else begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      ACCUM: begin
        if (m_idx_q != month_bin[3:0]) begin
          acc_d   = acc_q + {4'd0, dim(m_idx_q)};
          m_idx_d = m_idx_q + 4'd1;
        end else begin
          // Load the final sum straight into the low end of the dabble register.
          dd_d    = {12'd0, acc_q + {1'b0, day_bin}};
          acc_d   = acc_q + {1'b0, day_bin};
          cnt_d   = 4'd9;
          state_d = CONVERT;
        end
      end

      CONVERT: begin
        dd_d  = dd_shift;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hund_d  = dd_shift[20:17];
          tens_d  = dd_shift[16:13];
          ones_d  = dd_shift[12:9];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mon_msb_q <= 4'd0;
      mon_lsb_q <= 4'd0;
      day_msb_q <= 4'd0;
      day_lsb_q <= 4'd0;
      acc_q     <= 9'd0;
      m_idx_q   <= 4'd0;
      cnt_q     <= 4'd0;
      dd_q      <= 21'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      hund_q    <= 4'd0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      mon_msb_q <= mon_msb_d;
      mon_lsb_q <= mon_lsb_d;
      day_msb_q <= day_msb_d;
      day_lsb_q <= day_lsb_d;
      acc_q     <= acc_d;
      m_idx_q   <= m_idx_d;
      cnt_q     <= cnt_d;
      dd_q      <= dd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      hund_q    <= hund_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign doy_hundreds = hund_q;
  assign doy_tens     = tens_q;
  assign doy_ones     = ones_q;

endmodule

// File: tb/tb_date_to_day_encoder.sv
// Scoreboard bench: a non-leap and a leap instance share stimulus; each has its own
// expected-event queue drained by a negedge monitor.
`timescale 1ns/1ps
module tb_date_to_day_encoder;

  typedef struct {
    bit         is_err;
    logic [11:0] digits;
    int         lat;
    int         t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] month_msb = 4'd0, month_lsb = 4'd0, day_msb = 4'd0, day_lsb = 4'd0;

  logic       busy0, done0, error0, busy1, done1, error1;
  logic [3:0] h0, t0d, o0, h1, t1d, o1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last0 = 0;
  int last1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  date_to_day_encoder #(.LEAP_YEAR(0)) u_d0 (
    .ADC_CLK_10(clk), .reset_n(reset_n), .start(start),
    .month_msb(month_msb), .month_lsb(month_lsb), .day_msb(day_msb), .day_lsb(day_lsb),
    .busy(busy0), .done(done0), .error(error0),
    .doy_hundreds(h0), .doy_tens(t0d), .doy_ones(o0));

  date_to_day_encoder #(.LEAP_YEAR(1)) u_d1 (
    .ADC_CLK_10(clk), .reset_n(reset_n), .start(start),
    .month_msb(month_msb), .month_lsb(month_lsb), .day_msb(day_msb), .day_lsb(day_lsb),
    .busy(busy1), .done(done1), .error(error1),
    .doy_hundreds(h1), .doy_tens(t1d), .doy_ones(o1));

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic mon(input int idx, input logic d, input logic e, input logic b,
                     input logic [11:0] dig);
    exp_t x;
    int   qs;
    if (d || e) begin
      qs = (idx == 0) ? q0.size() : q1.size();
      chk("event_expected", idx, int'(qs > 0), 1);
      if (qs > 0) begin
        x = (idx == 0) ? q0.pop_front() : q1.pop_front();
        chk("error_vs_done", idx, int'(e), int'(x.is_err));
        chk("done_error_exclusive", idx, int'(d && e), 0);
        chk("busy_low_at_event", idx, int'(b), 0);
        chk("doy_digits", idx, int'(dig), int'(x.digits));
        chk("latency", idx, cyc - x.t0 - 1, x.lat);
        $display("event dut%0d err=%0d doy=%03h lat=%0d", idx, e, dig, cyc - x.t0 - 1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      mon(0, done0, error0, busy0, {h0, t0d, o0});
      mon(1, done1, error1, busy1, {h1, t1d, o1});
    end
  end

  task automatic push(input int idx, input bit err, input int val, input int lat, input int ts);
    exp_t x;
    int   v;
    if (idx == 0) begin
      if (!err) last0 = val;
      v = last0;
    end else begin
      if (!err) last1 = val;
      v = last1;
    end
    x.is_err = err;
    x.digits = to_bcd(v);
    x.lat    = lat;
    x.t0     = ts;
    if (idx == 0) q0.push_back(x);
    else          q1.push_back(x);
  endtask

  // Drive a date with a one-cycle start; leaves the bench at the negedge after E0.
  task automatic issue(input logic [3:0] mm, input logic [3:0] ml,
                       input logic [3:0] dm, input logic [3:0] dl,
                       input bit e0, input int v0, input int l0,
                       input bit e1, input int v1, input int l1, input bit do_push);
    @(negedge clk);
    month_msb = mm; month_lsb = ml; day_msb = dm; day_lsb = dl;
    start = 1'b1;
    if (do_push) begin
      push(0, e0, v0, l0, cyc);
      push(1, e1, v1, l1, cyc);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int busy_cycles);
    int n;
    n = 0;
    busy_cycles = 0;
    while ((busy0 || busy1) && n < 40) begin
      busy_cycles += int'(busy0);
      n++;
      @(negedge clk);
    end
    chk("idle_within_bound", 0, int'(busy0 || busy1), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 0, int'(busy0), 0);
    chk({tag, "_done"}, 0, int'(done0), 0);
    chk({tag, "_error"}, 0, int'(error0), 0);
    chk({tag, "_doy"}, 0, int'({h0, t0d, o0}), 0);
    chk({tag, "_busy"}, 1, int'(busy1), 0);
    chk({tag, "_done"}, 1, int'(done1), 0);
    chk({tag, "_error"}, 1, int'(error1), 0);
    chk({tag, "_doy"}, 1, int'({h1, t1d, o1}), 0);
  endtask

  initial begin
    int bc;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;

    // 01/01 -> 1, 11 clocks, busy for 11 clocks
    issue(4'd0, 4'd1, 4'd0, 4'd1, 0, 1, 11, 0, 1, 11, 1);
    wait_idle(bc);
    chk("busy_cycles_jan1", 0, bc, 11);

    // 12/31 -> 365 / 366
    issue(4'd1, 4'd2, 4'd3, 4'd1, 0, 365, 22, 0, 366, 22, 1);
    wait_idle(bc);

    // 02/29 -> invalid non-leap, 60 on leap
    issue(4'd0, 4'd2, 4'd2, 4'd9, 1, 0, 1, 0, 60, 12, 1);
    wait_idle(bc);

    // invalid dates on both instances
    issue(4'd0, 4'hA, 4'd0, 4'd1, 1, 0, 1, 1, 0, 1, 1);
    wait_idle(bc);
    issue(4'd1, 4'd3, 4'd0, 4'd1, 1, 0, 1, 1, 0, 1, 1);
    wait_idle(bc);
    issue(4'd0, 4'd5, 4'd0, 4'd0, 1, 0, 1, 1, 0, 1, 1);
    wait_idle(bc);
    issue(4'd0, 4'd4, 4'd3, 4'd1, 1, 0, 1, 1, 0, 1, 1);
    wait_idle(bc);

    // 07/04 with input churn and a second start while busy
    issue(4'd0, 4'd7, 4'd0, 4'd4, 0, 185, 17, 0, 186, 17, 1);
    month_msb = 4'd0; month_lsb = 4'd1; day_msb = 4'd0; day_lsb = 4'd1;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    month_msb = 4'd1; month_lsb = 4'd2; day_msb = 4'd3; day_lsb = 4'd1;
    wait_idle(bc);

    // 09/15 aborted by reset during CONVERT, then rerun
    issue(4'd0, 4'd9, 4'd1, 4'd5, 0, 0, 0, 0, 0, 0, 0);
    repeat (12) @(negedge clk);
    chk("busy_before_abort", 0, int'(busy0), 1);
    reset_n = 1'b0;
    #1;
    check_zero("abort");
    last0 = 0;
    last1 = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    issue(4'd0, 4'd9, 4'd1, 4'd5, 0, 258, 19, 0, 259, 19, 1);
    wait_idle(bc);

    chk("pending_events", 0, q0.size(), 0);
    chk("pending_events", 1, q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
